// File: rtl/sha256_w_mem_stage_23_2_hs.sv
// sha256_w_mem_stage_23_2_hs: second-block W expander stage, appends one schedule word to a
// seven-word window and forwards it through a two-entry skid buffer with valid/ready handshake.
module sha256_w_mem_stage_23_2_hs #(
    parameter logic [31:0] K_ADD = 32'h00000000
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [223:0] block_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] block_out,
    output logic [1:0]   occupancy
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t       state;
    logic [255:0] m, s, window;
    logic [31:0]  x0, x1, x6, sig0, sig1;
    logic         accept, emit;

    assign x0     = block_in[223:192];
    assign x1     = block_in[191:160];
    assign x6     = block_in[31:0];
    assign sig0   = {x1[6:0], x1[31:7]} ^ {x1[17:0], x1[31:18]} ^ (x1 >> 3);
    assign sig1   = {x6[16:0], x6[31:17]} ^ {x6[18:0], x6[31:19]} ^ (x6 >> 10);
    assign window = {block_in, sig1 + sig0 + x0 + K_ADD};

    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;
    assign block_out = m;

    // valid_M is tracked by out_valid, valid_S by ~in_ready; both are registered with the state
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= EMPTY;
            m         <= '0;
            s         <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= 2'd0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= 2'd0;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    m         <= window;
                    state     <= ONE;
                    out_valid <= 1'b1;
                    occupancy <= 2'd1;
                end
                ONE: if (accept && emit) begin
                    m <= window;
                end else if (accept) begin
                    s         <= window;
                    state     <= FULL;
                    in_ready  <= 1'b0;
                    occupancy <= 2'd2;
                end else if (emit) begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    occupancy <= 2'd0;
                end
                FULL: if (emit) begin
                    m         <= s;
                    state     <= ONE;
                    in_ready  <= 1'b1;
                    occupancy <= 2'd1;
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    occupancy <= 2'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_w_mem_stage_23_2_hs.sv
// tb_sha256_w_mem_stage_23_2_hs: random and directed checks of the W stage against a queue-based
// FIFO model that computes each expected window straight from the sigma formulas.
module tb_sha256_w_mem_stage_23_2_hs;
    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [223:0] block_in = '0;
    logic         in_ready, out_valid, k_in_ready, k_out_valid;
    logic [255:0] block_out, k_block_out;
    logic [1:0]   occupancy, k_occupancy;

    int n_cmp = 0;
    int n_err = 0;
    logic [255:0] q[$];

    always #5 CLK = ~CLK;

    sha256_w_mem_stage_23_2_hs dut (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .block_in(block_in), .out_valid(out_valid), .out_ready(out_ready),
        .block_out(block_out), .occupancy(occupancy)
    );

    sha256_w_mem_stage_23_2_hs #(.K_ADD(32'h00000280)) dut_k (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(k_in_ready),
        .block_in(block_in), .out_valid(k_out_valid), .out_ready(out_ready),
        .block_out(k_block_out), .occupancy(k_occupancy)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [255:0] ref_window(input logic [223:0] b, input logic [31:0] k);
        logic [31:0] a, c, w;
        a = b[191:160];
        c = b[31:0];
        w = (rotr(c, 17) ^ rotr(c, 19) ^ (c >> 10)) + (rotr(a, 7) ^ rotr(a, 18) ^ (a >> 3))
            + b[223:192] + k;
        return {b, w};
    endfunction

    function automatic logic [223:0] mkwin(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] g);
        return {a, b, 128'd0, g};
    endfunction

    function automatic logic [223:0] rnd_win();
        logic [223:0] r;
        for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_outputs();
        chk("occupancy", 256'(occupancy), 256'(q.size()));
        chk("in_ready", 256'(in_ready), 256'(q.size() < 2));
        chk("out_valid", 256'(out_valid), 256'(q.size() != 0));
        if (q.size() != 0) chk("block_out", block_out, q[0]);
    endtask

    // called at a falling edge: check, drive, clock, update model, return at next falling edge
    task automatic cycle(input logic iv, input logic [223:0] b, input logic ordy, input logic fl);
        bit acc, em;
        check_outputs();
        in_valid = iv;
        block_in = b;
        out_ready = ordy;
        flush = fl;
        @(posedge CLK);
        if (fl) q.delete();
        else begin
            acc = iv && q.size() < 2;
            em = ordy && q.size() > 0;
            if (em) void'(q.pop_front());
            if (acc) q.push_back(ref_window(b, 32'd0));
        end
        @(negedge CLK);
    endtask

    task automatic send_w(input string tag, input logic [223:0] b, input logic [31:0] exp_w);
        cycle(1'b1, b, 1'b1, 1'b0);
        chk(tag, 256'(block_out[31:0]), 256'(exp_w));
    endtask

    initial begin
        logic [223:0] wa, wb, wc;
        @(negedge CLK);
        chk("rst_out_valid", 256'(out_valid), 256'd0);
        chk("rst_in_ready", 256'(in_ready), 256'd1);
        chk("rst_block_out", block_out, 256'd0);
        @(negedge CLK);
        RST = 1'b1;
        cycle(1'b0, '0, 1'b1, 1'b0);

        send_w("w_x0", mkwin(32'd1, 32'd0, 32'd0), 32'h00000001);
        send_w("w_x1", mkwin(32'd0, 32'd1, 32'd0), 32'h02004000);
        send_w("w_x6", mkwin(32'd0, 32'd0, 32'd1), 32'h0000A000);
        send_w("w_all", mkwin(32'd1, 32'd1, 32'd1), 32'h0200E001);
        send_w("w_zero", mkwin(32'd0, 32'd0, 32'd0), 32'h00000000);

        cycle(1'b1, mkwin(32'hFFFFFFFF, 32'd0, 32'd0), 1'b1, 1'b0);
        chk("k_w_new", 256'(k_block_out[31:0]), 256'(32'h0000027F));
        chk("k_words", 256'(k_block_out[255:32]), 256'(mkwin(32'hFFFFFFFF, 32'd0, 32'd0)));
        cycle(1'b0, '0, 1'b1, 1'b0);

        // back-pressure: A and B fill the buffer, C is held off until space frees
        wa = rnd_win(); wb = rnd_win(); wc = rnd_win();
        cycle(1'b1, wa, 1'b0, 1'b0);
        cycle(1'b1, wb, 1'b0, 1'b0);
        chk("bp_occ_full", 256'(occupancy), 256'd2);
        cycle(1'b1, wc, 1'b0, 1'b0);
        cycle(1'b1, wc, 1'b0, 1'b0);
        cycle(1'b1, wc, 1'b1, 1'b0);
        cycle(1'b1, wc, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 100; i++) cycle(1'b1, rnd_win(), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), rnd_win(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 39) == 0));

        // flush while full with a simultaneous accept
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, rnd_win(), 1'b0, 1'b0);
        cycle(1'b1, rnd_win(), 1'b0, 1'b0);
        cycle(1'b1, rnd_win(), 1'b0, 1'b1);
        chk("flush_occ", 256'(occupancy), 256'd0);
        chk("flush_out_valid", 256'(out_valid), 256'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // asynchronous reset mid-stream while full
        cycle(1'b1, rnd_win(), 1'b0, 1'b0);
        cycle(1'b1, rnd_win(), 1'b0, 1'b0);
        chk("pre_rst_occ", 256'(occupancy), 256'd2);
        RST = 1'b0;
        #1;
        chk("arst_out_valid", 256'(out_valid), 256'd0);
        chk("arst_block_out", block_out, 256'd0);
        chk("arst_occ", 256'(occupancy), 256'd0);
        chk("arst_in_ready", 256'(in_ready), 256'd1);
        q.delete();
        in_valid = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 20; i++) cycle(1'b1, rnd_win(), 1'($urandom_range(0, 1)), 1'b0);
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
